// File: rtl/bench_reporter.sv
// Snapshots bench-engine results on each rising edge of done and streams them as a fixed byte frame.
// Optional trailing XOR checksum byte enabled by defining BENCH_REPORT_CKSUM_EN.
module bench_reporter #(
    parameter logic [7:0]  HEADER = 8'hA5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done,
    input  logic [1:0]       winner_code,
    input  logic [31:0]      t_cond0,
    input  logic [31:0]      t_cond1,
    input  logic [31:0]      t_cond2,
    input  logic [31:0]      t_cond3,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int unsigned IDX_W     = 5;
    localparam int unsigned DATA_LAST = 17;
`ifdef BENCH_REPORT_CKSUM_EN
    localparam int unsigned LAST = 18;
`else
    localparam int unsigned LAST = 17;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             state_q;
    logic               done_q;
    logic [IDX_W-1:0]   byte_idx_q;
    logic [IDX_W-1:0]   byte_idx_d;
    logic [1:0]         win_q;
    logic [31:0]        t_q [4];
    logic [7:0]         tx_data_q;
    logic               tx_valid_q;
    logic               busy_q;
    logic               frame_done_q;
    logic               overrun_q;
    logic [CNT_W-1:0]   frames_q;
    logic               done_rise_c;
    logic               handshake_c;
    logic [7:0]         frame_bytes [18];
    logic [7:0]         next_byte_c;
`ifdef BENCH_REPORT_CKSUM_EN
    logic [7:0]         cksum_q;
    logic [7:0]         cksum_d;
`endif

    assign done_rise_c = done & ~done_q;
    assign handshake_c = tx_valid_q & tx_ready;
    assign byte_idx_d  = byte_idx_q + IDX_W'(1);

    // Frame image built from the snapshot only, so live inputs never leak into a frame in flight.
    always_comb begin
        frame_bytes[0] = HEADER;
        frame_bytes[1] = {6'b0, win_q};
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 4; b++) begin
                frame_bytes[2 + 4*c + b] = t_q[c][8*(3-b) +: 8];
            end
        end
    end

`ifdef BENCH_REPORT_CKSUM_EN
    // Running XOR covers every accepted byte except the header.
    always_comb begin
        cksum_d = cksum_q;
        if (byte_idx_q != IDX_W'(0)) begin
            cksum_d = cksum_q ^ tx_data_q;
        end
    end
`endif

    always_comb begin
        next_byte_c = 8'h00;
        if (byte_idx_d <= IDX_W'(DATA_LAST)) begin
            next_byte_c = frame_bytes[byte_idx_d];
        end
`ifdef BENCH_REPORT_CKSUM_EN
        else begin
            next_byte_c = cksum_d;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            done_q       <= 1'b0;
            byte_idx_q   <= '0;
            win_q        <= '0;
            for (int c = 0; c < 4; c++) begin
                t_q[c] <= '0;
            end
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            frames_q     <= '0;
`ifdef BENCH_REPORT_CKSUM_EN
            cksum_q      <= '0;
`endif
        end else begin
            done_q       <= done;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (done_rise_c) begin
                        win_q      <= winner_code;
                        t_q[0]     <= t_cond0;
                        t_q[1]     <= t_cond1;
                        t_q[2]     <= t_cond2;
                        t_q[3]     <= t_cond3;
                        byte_idx_q <= '0;
                        tx_data_q  <= HEADER;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
`ifdef BENCH_REPORT_CKSUM_EN
                        cksum_q    <= '0;
`endif
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // A new run finishing mid-frame (including on the last byte) is flagged, never queued.
                    if (done_rise_c) begin
                        overrun_q <= 1'b1;
                    end
                    if (handshake_c) begin
`ifdef BENCH_REPORT_CKSUM_EN
                        cksum_q <= cksum_d;
`endif
                        if (byte_idx_q == IDX_W'(LAST)) begin
                            tx_valid_q   <= 1'b0;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            frames_q     <= frames_q + CNT_W'(1);
                            state_q      <= ST_IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_d;
                            tx_data_q  <= next_byte_c;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_bench_reporter.sv
// Directed bench for bench_reporter: frame content, backpressure, snapshot, overrun, reset abort, counter wrap.
module tb_bench_reporter;

`ifdef BENCH_REPORT_CKSUM_EN
    localparam int LEN = 19;
`else
    localparam int LEN = 18;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        done = 1'b0;
    logic [1:0]  winner_code = 2'd0;
    logic [31:0] t_cond0 = 32'd0;
    logic [31:0] t_cond1 = 32'd0;
    logic [31:0] t_cond2 = 32'd0;
    logic [31:0] t_cond3 = 32'd0;
    logic        tx_ready = 1'b0;

    logic [7:0]  tx_data;
    logic        tx_valid, busy, frame_done, overrun;
    logic [15:0] frames_sent;
    logic [7:0]  tx_data_w;
    logic        tx_valid_w, busy_w, frame_done_w, overrun_w;
    logic [1:0]  frames_sent_w;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_b [19];
    logic [7:0] got [32];
    int nrx;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    bench_reporter dut (
        .clk(clk), .rst_n(rst_n), .done(done), .winner_code(winner_code),
        .t_cond0(t_cond0), .t_cond1(t_cond1), .t_cond2(t_cond2), .t_cond3(t_cond3),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .frames_sent(frames_sent)
    );

    bench_reporter #(.CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .done(done), .winner_code(winner_code),
        .t_cond0(t_cond0), .t_cond1(t_cond1), .t_cond2(t_cond2), .t_cond3(t_cond3),
        .tx_data(tx_data_w), .tx_valid(tx_valid_w), .tx_ready(tx_ready), .busy(busy_w),
        .frame_done(frame_done_w), .overrun(overrun_w), .frames_sent(frames_sent_w)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp();
        logic [31:0] tv [4];
        logic [7:0]  x;
        tv[0] = t_cond0; tv[1] = t_cond1; tv[2] = t_cond2; tv[3] = t_cond3;
        exp_b[0] = 8'hA5;
        exp_b[1] = {6'b0, winner_code};
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 4; b++) begin
                exp_b[2 + 4*c + b] = tv[c][8*(3-b) +: 8];
            end
        end
        x = 8'h00;
        for (int i = 1; i < 18; i++) x = x ^ exp_b[i];
        exp_b[18] = x;
    endtask

    task automatic start_frame();
        done = 1'b0;
        step();
        done = 1'b1;
        step();
    endtask

    // mode 1: corrupt t_cond0 mid-frame; mode 2: new done edge mid-frame
    task automatic send_frame(input bit bp, input int mode);
        logic [7:0] prev;
        bit hold;
        bit r;
        int cyc;
        nrx = 0; hold = 1'b0; cyc = 0; prev = 8'h00;
        while (nrx < LEN && cyc < 400) begin
            r = bp ? pat[cyc % 4] : 1'b1;
            tx_ready = r;
            if (hold) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev) begin
                    errors++;
                    $display("FAIL stall_hold byte %0d: valid=%b data=%h required valid=1 data=%h", nrx, tx_valid, tx_data, prev);
                end
            end
            hold = 1'b0;
            if (tx_valid === 1'b1 && r) begin
                got[nrx] = tx_data;
                nrx++;
                if (mode == 1 && nrx == 2) t_cond0 = 32'hFFFF_FFFF;
                if (mode == 2 && nrx == 5) done = 1'b0;
                if (mode == 2 && nrx == 7) done = 1'b1;
            end else if (tx_valid === 1'b1) begin
                hold = 1'b1;
                prev = tx_data;
            end
            step();
            cyc++;
        end
        checks++;
        if (nrx != LEN) begin
            errors++;
            $display("FAIL frame_len: got %0d bytes required %0d", nrx, LEN);
        end
        checks++;
        if (frame_done !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: frame_done=%b tx_valid=%b busy=%b required 1,0,0", frame_done, tx_valid, busy);
        end
        step();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_pulse: frame_done=%b required 0", frame_done);
        end
        for (int i = 0; i < LEN; i++) begin
            if (i < nrx) begin
                checks++;
                if (got[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL frame_byte[%0d]: got %h required %h", i, got[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic check_fs(input string name, input logic [15:0] req);
        checks++;
        if (frames_sent !== req) begin
            errors++;
            $display("FAIL %s: frames_sent=%0d required %0d", name, frames_sent, req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (tx_data !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
            overrun !== 1'b0 || frames_sent !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: data=%h valid=%b busy=%b fd=%b ovr=%b fs=%0d required all 0",
                     tx_data, tx_valid, busy, frame_done, overrun, frames_sent);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        winner_code = 2'd3;
        t_cond0 = 32'h10; t_cond1 = 32'h20; t_cond2 = 32'h30; t_cond3 = 32'h08;
        build_exp();
`ifdef BENCH_REPORT_CKSUM_EN
        checks++;
        if (exp_b[18] !== 8'h0B) begin
            errors++;
            $display("FAIL cksum_model: got %h required 0b", exp_b[18]);
        end
`endif
        done = 1'b0;
        step();
        done = 1'b1;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_early: tx_valid=%b required 0", tx_valid);
        end
        step();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL valid_latency: valid=%b data=%h busy=%b required 1,a5,1", tx_valid, tx_data, busy);
        end
        send_frame(1'b0, 0);
        check_fs("basic_count", 16'd1);
    endtask

    task automatic test_backpressure();
        start_frame();
        send_frame(1'b1, 0);
        check_fs("bp_count", 16'd2);
    endtask

    task automatic test_snapshot();
        start_frame();
        send_frame(1'b0, 1);
        check_fs("snap_count", 16'd3);
        t_cond0 = 32'h10;
    endtask

    task automatic test_held_done();
        int seen;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx_valid !== 1'b0 || busy !== 1'b0) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL held_done_retrigger: active cycles=%0d required 0", seen);
        end
        check_fs("held_count", 16'd3);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_early: overrun=%b required 0", overrun);
        end
    endtask

    task automatic test_overrun();
        int seen;
        start_frame();
        send_frame(1'b0, 2);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: overrun=%b required 1", overrun);
        end
        check_fs("overrun_count", 16'd4);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid !== 1'b0) seen++;
            step();
        end
        checks++;
        if (seen != 0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_queued: valid cycles=%0d overrun=%b required 0,1", seen, overrun);
        end
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b1;
        start_frame();
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (busy !== 1'b1 || tx_data !== exp_b[6]) begin
            errors++;
            $display("FAIL mid_frame_pos: busy=%b data=%h required 1,%h", busy, tx_data, exp_b[6]);
        end
        rst_n = 1'b0;
        done = 1'b0;
        step();
        checks++;
        if (tx_data !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
            overrun !== 1'b0 || frames_sent !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_values: data=%h valid=%b busy=%b fd=%b ovr=%b fs=%0d required all 0",
                     tx_data, tx_valid, busy, frame_done, overrun, frames_sent);
        end
        rst_n = 1'b1;
        step();
        start_frame();
        send_frame(1'b0, 0);
        check_fs("post_reset_count", 16'd1);
    endtask

    task automatic test_wrap();
        logic [1:0] req_w [4];
        req_w = '{2'd1, 2'd2, 2'd3, 2'd0};
        rst_n = 1'b0;
        done = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            start_frame();
            send_frame(1'b0, 0);
            checks++;
            if (frames_sent_w !== req_w[k]) begin
                errors++;
                $display("FAIL wrap_count[%0d]: frames_sent=%0d required %0d", k, frames_sent_w, req_w[k]);
            end
        end
        check_fs("wide_count", 16'd4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_held_done();
        test_overrun();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
